// File: rtl/uart_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter_pkg
// Shared types and constants for the UART port arbiter.
//   arb_mode_t : mode FSM states (BOOT / RUN plus drain and escape-ack states)
//   rx_dest_t  : destination tag stored alongside a buffered RX byte
//   tx_src_t   : TX round-robin pointer value (which source was granted last)
//   ASCII_*    : character constants used by the arbiter
// -----------------------------------------------------------------------------
package uart_port_arbiter_pkg;

   // ASCII constants
   localparam logic [7:0] ASCII_ESC  = 8'h1B;
   localparam logic [7:0] ASCII_BANG = 8'h21;

   typedef enum logic [2:0] {
      M_BOOT    = 3'd0,
      M_TO_RUN  = 3'd1,
      M_RUN     = 3'd2,
      M_TO_BOOT = 3'd3,
      M_ESC_ACK = 3'd4
   } arb_mode_t;

   typedef enum logic {
      DEST_BIOS = 1'b0,
      DEST_CPU  = 1'b1
   } rx_dest_t;

   typedef enum logic {
      SRC_BIOS = 1'b0,
      SRC_CPU  = 1'b1
   } tx_src_t;

endpackage

// File: rtl/uart_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter_if
// Bundles every stream and control signal of the UART port arbiter.
//   slave  : arbiter side (drives o_* signals, samples i_* signals)
//   master : environment side (UART, bios, CPU and control drivers)
// Streams: rx (UART->arb), tx (arb->UART), bios (arb->bios), bios_tx
// (bios->arb), cpu (arb->CPU), cpu_tx (CPU->arb); control: i_run_req,
// o_mode, o_esc.
// -----------------------------------------------------------------------------
interface uart_port_arbiter_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] i_rx_data;
   logic              i_rx_valid;
   logic              o_rx_ready;
   logic [DATA_W-1:0] o_tx_data;
   logic              o_tx_valid;
   logic              i_tx_ready;
   logic [DATA_W-1:0] o_bios_data;
   logic              o_bios_valid;
   logic              i_bios_ready;
   logic [DATA_W-1:0] i_bios_tx_data;
   logic              i_bios_tx_valid;
   logic              o_bios_tx_ready;
   logic [DATA_W-1:0] o_cpu_data;
   logic              o_cpu_valid;
   logic              i_cpu_ready;
   logic [DATA_W-1:0] i_cpu_tx_data;
   logic              i_cpu_tx_valid;
   logic              o_cpu_tx_ready;
   logic              i_run_req;
   logic              o_mode;
   logic              o_esc;

   modport slave (
      input  i_rx_data, i_rx_valid, i_tx_ready, i_bios_ready,
             i_bios_tx_data, i_bios_tx_valid, i_cpu_ready,
             i_cpu_tx_data, i_cpu_tx_valid, i_run_req,
      output o_rx_ready, o_tx_data, o_tx_valid, o_bios_data, o_bios_valid,
             o_bios_tx_ready, o_cpu_data, o_cpu_valid, o_cpu_tx_ready,
             o_mode, o_esc
   );

   modport master (
      output i_rx_data, i_rx_valid, i_tx_ready, i_bios_ready,
             i_bios_tx_data, i_bios_tx_valid, i_cpu_ready,
             i_cpu_tx_data, i_cpu_tx_valid, i_run_req,
      input  o_rx_ready, o_tx_data, o_tx_valid, o_bios_data, o_bios_valid,
             o_bios_tx_ready, o_cpu_data, o_cpu_valid, o_cpu_tx_ready,
             o_mode, o_esc
   );
endinterface

// File: rtl/uart_port_arbiter_axis_reg1.sv
// -----------------------------------------------------------------------------
// axis_reg1
// One-deep valid/ready register slice with clock enable.
//   clk, rst     : clock, asynchronous active-high reset (drops the entry)
//   clk_en_i     : entry updates only when high; s_ready_o is gated by it
//   s_data_i / s_valid_i / s_ready_o : upstream handshake
//   m_data_o / m_valid_o / m_ready_i : downstream handshake
// Accepts a new word when empty or when the held word leaves in the same
// cycle, giving one word per cycle at full throughput.
// -----------------------------------------------------------------------------
module axis_reg1 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en_i,
   input  logic [W-1:0] s_data_i,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   output logic [W-1:0] m_data_o,
   output logic         m_valid_o,
   input  logic         m_ready_i
);
   logic         valid_q;
   logic [W-1:0] data_q;

   assign s_ready_o = clk_en_i & (~valid_q | m_ready_i);
   assign m_valid_o = valid_q;
   assign m_data_o  = data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clk_en_i) begin
         if (s_valid_i && s_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= s_data_i;
         end else if (m_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/uart_port_arbiter.sv
// -----------------------------------------------------------------------------
// uart_port_arbiter
// Shares one UART byte stream between the bios command parser and the CPU.
//   BOOT : RX bytes go to bios, TX carries bios replies only.
//   RUN  : RX bytes go to the CPU, TX is round-robin between CPU and bios.
//   Mode changes pass through drain states that close intake until both
//   one-deep buffers are empty. ESC_COUNT consecutive ESC_CHAR bytes in RUN
//   return the port to BOOT (the last escape byte is swallowed).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clk_en   : all state advances only when high; every ready is gated by it
//   bus      : uart_port_arbiter_if.slave (all streams, i_run_req, o_mode,
//              o_esc)
// Build option: define UART_ARB_ESC_ACK_EN to send '!' on the UART after an
// escape-triggered return, before entering BOOT and pulsing o_esc.
// -----------------------------------------------------------------------------
module uart_port_arbiter
   import uart_port_arbiter_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] ESC_CHAR  = DATA_W'(ASCII_ESC),
   parameter int                ESC_COUNT = 3
) (
   input logic                clk,
   input logic                rst,
   input logic                clk_en,
   uart_port_arbiter_if.slave bus
);
   localparam logic [3:0] ESC_MAX  = 4'(ESC_COUNT);
   localparam logic [3:0] ESC_LAST = 4'(ESC_COUNT - 1);

   arb_mode_t  state_q;
   logic       mode_q;
   logic       esc_q;
   logic [3:0] esc_cnt_q;
   tx_src_t    last_q;

   // ---------------- RX path ----------------
   logic              rx_open, rx_is_esc, rx_esc_last, rx_fire;
   logic              rx_s_valid, rx_s_ready, rx_m_valid, rx_m_ready;
   logic              rx_m_to_cpu;
   rx_dest_t          rx_tag;
   logic [DATA_W:0]   rx_s_payload, rx_m_payload;

   assign rx_open     = (state_q == M_BOOT) || (state_q == M_RUN);
   assign rx_is_esc   = (bus.i_rx_data == ESC_CHAR);
   // The final escape byte of the sequence is handshaken but never buffered.
   assign rx_esc_last = (state_q == M_RUN) && rx_is_esc && (esc_cnt_q == ESC_LAST);
   assign bus.o_rx_ready = rx_s_ready & rx_open;
   assign rx_fire     = bus.i_rx_valid & bus.o_rx_ready;
   assign rx_s_valid  = bus.i_rx_valid & rx_open & ~rx_esc_last;
   assign rx_tag      = (state_q == M_RUN) ? DEST_CPU : DEST_BIOS;
   assign rx_s_payload = {rx_tag, bus.i_rx_data};

   assign rx_m_to_cpu = (rx_m_payload[DATA_W] == DEST_CPU);
   assign rx_m_ready  = rx_m_to_cpu ? bus.i_cpu_ready : bus.i_bios_ready;

   assign bus.o_bios_valid = rx_m_valid & ~rx_m_to_cpu;
   assign bus.o_cpu_valid  = rx_m_valid &  rx_m_to_cpu;
   assign bus.o_bios_data  = rx_m_payload[DATA_W-1:0];
   assign bus.o_cpu_data   = rx_m_payload[DATA_W-1:0];

   axis_reg1 #(.W(DATA_W + 1)) u_rx_reg (
      .clk       (clk),
      .rst       (rst),
      .clk_en_i  (clk_en),
      .s_data_i  (rx_s_payload),
      .s_valid_i (rx_s_valid),
      .s_ready_o (rx_s_ready),
      .m_data_o  (rx_m_payload),
      .m_valid_o (rx_m_valid),
      .m_ready_i (rx_m_ready)
   );

   // ---------------- TX path ----------------
   logic              bios_sel, cpu_sel, cpu_pick, ack_inject;
   logic              bios_tx_fire, cpu_tx_fire;
   logic              tx_s_valid, tx_s_ready, tx_m_valid;
   logic [DATA_W-1:0] tx_s_data, tx_m_data;

   // Only one source can be selected while both are valid, so at most one
   // intake handshake completes per cycle.
   assign bios_sel = (state_q == M_BOOT) ||
                     ((state_q == M_RUN) && (!bus.i_cpu_tx_valid || last_q == SRC_CPU));
   assign cpu_sel  = (state_q == M_RUN) &&
                     (!bus.i_bios_tx_valid || last_q == SRC_BIOS);

   assign bus.o_bios_tx_ready = tx_s_ready & bios_sel;
   assign bus.o_cpu_tx_ready  = tx_s_ready & cpu_sel;
   assign bios_tx_fire = bus.i_bios_tx_valid & bus.o_bios_tx_ready;
   assign cpu_tx_fire  = bus.i_cpu_tx_valid  & bus.o_cpu_tx_ready;
   assign cpu_pick     = cpu_sel & bus.i_cpu_tx_valid;

`ifdef UART_ARB_ESC_ACK_EN
   // The TX buffer is empty on entry, so inject exactly once.
   assign ack_inject = (state_q == M_ESC_ACK) && !tx_m_valid;
`else
   assign ack_inject = 1'b0;
`endif

   assign tx_s_valid = ack_inject | (bus.i_bios_tx_valid & bios_sel) | cpu_pick;
   assign tx_s_data  = ack_inject ? DATA_W'(ASCII_BANG) :
                       (cpu_pick ? bus.i_cpu_tx_data : bus.i_bios_tx_data);

   axis_reg1 #(.W(DATA_W)) u_tx_reg (
      .clk       (clk),
      .rst       (rst),
      .clk_en_i  (clk_en),
      .s_data_i  (tx_s_data),
      .s_valid_i (tx_s_valid),
      .s_ready_o (tx_s_ready),
      .m_data_o  (tx_m_data),
      .m_valid_o (tx_m_valid),
      .m_ready_i (bus.i_tx_ready)
   );

   assign bus.o_tx_valid = tx_m_valid;
   assign bus.o_tx_data  = tx_m_data;

   // ---------------- Mode FSM ----------------
   logic bufs_empty;
   assign bufs_empty = ~rx_m_valid & ~tx_m_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= M_BOOT;
         mode_q    <= 1'b0;
         esc_q     <= 1'b0;
         esc_cnt_q <= 4'd0;
         last_q    <= SRC_BIOS;
      end else if (clk_en) begin
         esc_q <= 1'b0;
         if (cpu_tx_fire) begin
            last_q <= SRC_CPU;
         end else if (bios_tx_fire) begin
            last_q <= SRC_BIOS;
         end
         case (state_q)
            M_BOOT: begin
               if (bus.i_run_req) begin
                  state_q <= M_TO_RUN;
               end
            end
            M_TO_RUN: begin
               if (bufs_empty) begin
                  state_q   <= M_RUN;
                  esc_cnt_q <= 4'd0;
                  mode_q    <= 1'b1;
               end
            end
            M_RUN: begin
               if (rx_fire) begin
                  if (rx_is_esc) begin
                     if (esc_cnt_q != ESC_MAX) begin
                        esc_cnt_q <= esc_cnt_q + 4'd1;
                     end
                     if (rx_esc_last) begin
                        state_q <= M_TO_BOOT;
                     end
                  end else begin
                     esc_cnt_q <= 4'd0;
                  end
               end
            end
            M_TO_BOOT: begin
               if (bufs_empty) begin
`ifdef UART_ARB_ESC_ACK_EN
                  state_q <= M_ESC_ACK;
`else
                  state_q <= M_BOOT;
                  mode_q  <= 1'b0;
                  esc_q   <= 1'b1;
`endif
               end
            end
            M_ESC_ACK: begin
`ifdef UART_ARB_ESC_ACK_EN
               if (tx_m_valid && bus.i_tx_ready) begin
                  state_q <= M_BOOT;
                  mode_q  <= 1'b0;
                  esc_q   <= 1'b1;
               end
`else
               state_q <= M_BOOT;
`endif
            end
            default: state_q <= M_BOOT;
         endcase
      end
   end

   assign bus.o_mode = mode_q;
   assign bus.o_esc  = esc_q;

endmodule
